// File: rtl/zigzag_block_buffer_pp.sv
// Ring of NUM_BANKS 8x8 coefficient blocks with row-wise writes and a
// per-block zigzag or raster read-out, one coefficient per handshake.
// A new block can be written while earlier blocks are still draining.
module zigzag_block_buffer_pp #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BANKS  = 2
) (
  input  logic                               clock,
  input  logic                               reset_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [8*DATA_WIDTH-1:0]            in_row_data,
  input  logic                               mode_zigzag,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic [5:0]                         out_pos,
  output logic                               out_last,
  output logic [$clog2(NUM_BANKS+1)-1:0]     blocks_pending
);

  // Bank indices are padded to a power-of-two slot count so every bank
  // index maps onto an existing slot; slots beyond NUM_BANKS stay idle.
  localparam int BW    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int CW    = $clog2(NUM_BANKS + 1);
  localparam int NSLOT = 1 << BW;
  localparam logic [BW-1:0] LAST_BANK = BW'(NUM_BANKS - 1);

  // Raster address visited at each zigzag scan position.
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  logic [DATA_WIDTH-1:0] mem_q [NSLOT][64];
  logic [DATA_WIDTH-1:0] mem_d [NSLOT][64];
  logic [NSLOT-1:0]      full_q, full_d;
  logic [NSLOT-1:0]      mode_q, mode_d;
  logic [BW-1:0]         wr_bank_q, wr_bank_d;
  logic [BW-1:0]         rd_bank_q, rd_bank_d;
  logic [2:0]            wr_row_q, wr_row_d;
  logic [5:0]            rd_pos_q, rd_pos_d;
  logic [CW-1:0]         pending_q, pending_d;
  logic                  wr_fire_s;
  logic                  rd_fire_s;
  logic [5:0]            rd_addr_s;

  // Handshake qualifiers, derived only from registered flags.
  always_comb begin
    in_ready  = !full_q[wr_bank_q];
    out_valid = full_q[rd_bank_q];
    wr_fire_s = in_valid && in_ready;
    rd_fire_s = out_valid && out_ready;
  end

  // Write side: store an accepted row and advance row/bank pointers.
  always_comb begin
    mem_d     = mem_q;
    wr_row_d  = wr_row_q;
    wr_bank_d = wr_bank_q;
    if (wr_fire_s) begin
      for (int c = 0; c < 8; c++) begin
        mem_d[wr_bank_q][{wr_row_q, 3'(c)}] =
          in_row_data[8*DATA_WIDTH-1-c*DATA_WIDTH -: DATA_WIDTH];
      end
      if (wr_row_q == 3'd7) begin
        wr_row_d  = 3'd0;
        wr_bank_d = (wr_bank_q == LAST_BANK) ? '0 : wr_bank_q + 1'b1;
      end else begin
        wr_row_d  = wr_row_q + 3'd1;
      end
    end else begin
      wr_row_d = wr_row_q;
    end
  end

  // Full/mode flags and read pointer; a set and a clear on different
  // banks in one cycle both land.
  always_comb begin
    full_d    = full_q;
    mode_d    = mode_q;
    rd_pos_d  = rd_pos_q;
    rd_bank_d = rd_bank_q;
    if (wr_fire_s && (wr_row_q == 3'd7)) begin
      full_d[wr_bank_q] = 1'b1;
      mode_d[wr_bank_q] = mode_zigzag;
    end else begin
      mode_d = mode_q;
    end
    if (rd_fire_s) begin
      if (rd_pos_q == 6'd63) begin
        full_d[rd_bank_q] = 1'b0;
        rd_pos_d          = 6'd0;
        rd_bank_d         = (rd_bank_q == LAST_BANK) ? '0 : rd_bank_q + 1'b1;
      end else begin
        rd_pos_d = rd_pos_q + 6'd1;
      end
    end else begin
      rd_pos_d = rd_pos_q;
    end
    pending_d = '0;
    for (int b = 0; b < NSLOT; b++) begin
      pending_d = pending_d + CW'(full_d[b]);
    end
  end

  // Read mux: everything here comes straight from registers.
  always_comb begin
    rd_addr_s      = mode_q[rd_bank_q] ? ZZ[rd_pos_q] : rd_pos_q;
    out_data       = mem_q[rd_bank_q][rd_addr_s];
    out_pos        = rd_pos_q;
    out_last       = out_valid && (rd_pos_q == 6'd63);
    blocks_pending = pending_q;
  end

  // State registers with synchronous active-low clear.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int b = 0; b < NSLOT; b++) begin
        for (int i = 0; i < 64; i++) begin
          mem_q[b][i] <= '0;
        end
      end
      full_q    <= '0;
      mode_q    <= '0;
      wr_bank_q <= '0;
      rd_bank_q <= '0;
      wr_row_q  <= 3'd0;
      rd_pos_q  <= 6'd0;
      pending_q <= '0;
    end else begin
      mem_q     <= mem_d;
      full_q    <= full_d;
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_row_q  <= wr_row_d;
      rd_pos_q  <= rd_pos_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_zigzag_block_buffer_pp.sv
// Bench for zigzag_block_buffer_pp: a two-bank instance checked every cycle
// against a queue-based model, plus a single-bank instance for throughput.
module tb_zigzag_block_buffer_pp;

  localparam int ZZ [64] = '{
    0, 1, 8, 16, 9, 2, 3, 10, 17, 24, 32, 25, 18, 11, 4, 5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13, 6, 7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Two-bank instance
  logic        a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_out_last;
  logic [63:0] a_row;
  logic [7:0]  a_out_data;
  logic [5:0]  a_out_pos;
  logic [1:0]  a_pend;

  // Single-bank instance
  logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_out_last;
  logic [63:0] b_row;
  logic [7:0]  b_out_data;
  logic [5:0]  b_out_pos;
  logic [0:0]  b_pend;

  zigzag_block_buffer_pp #(.DATA_WIDTH(8), .NUM_BANKS(2)) dut2 (
    .clock(clk), .reset_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_row_data(a_row), .mode_zigzag(a_mode), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_data(a_out_data), .out_pos(a_out_pos),
    .out_last(a_out_last), .blocks_pending(a_pend));

  zigzag_block_buffer_pp #(.DATA_WIDTH(8), .NUM_BANKS(1)) dut1 (
    .clock(clk), .reset_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_row_data(b_row), .mode_zigzag(b_mode), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_data(b_out_data), .out_pos(b_out_pos),
    .out_last(b_out_last), .blocks_pending(b_pend));

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model of the two-bank buffer: completed blocks are expanded
  // into their scan order and queued as the coefficients the consumer must see.
  int         exp_q[$];
  int         pend;
  int         rpos;
  int         wrow;
  int         blocks_done;
  int         pat;
  bit         row_loaded;
  logic [7:0] cur [64];
  bit         prev_hold;
  logic [7:0] prev_data;
  logic [5:0] prev_pos;

  task automatic model_clear();
    exp_q.delete();
    pend = 0; rpos = 0; wrow = 0; row_loaded = 0; prev_hold = 0;
  endtask

  // One clock of the two-bank DUT: compare outputs, drive inputs, advance model.
  task automatic cycle2(input bit want_wr, input bit zz, input bit rdy);
    bit exp_ir, exp_ov, exp_last, wf, rf;
    exp_ir   = (pend < 2);
    exp_ov   = (pend > 0);
    exp_last = exp_ov && (rpos == 63);
    n_checks++;
    if (a_in_ready !== exp_ir) $display("FAIL in_ready: got %b expected %b", a_in_ready, exp_ir);
    else n_pass++;
    n_checks++;
    if (a_out_valid !== exp_ov) $display("FAIL out_valid: got %b expected %b", a_out_valid, exp_ov);
    else n_pass++;
    n_checks++;
    if (a_pend !== 2'(pend)) $display("FAIL blocks_pending: got %0d expected %0d", a_pend, pend);
    else n_pass++;
    n_checks++;
    if (a_out_last !== exp_last) $display("FAIL out_last: got %b expected %b", a_out_last, exp_last);
    else n_pass++;
    if (exp_ov) begin
      n_checks++;
      if (a_out_data !== 8'(exp_q[0])) $display("FAIL out_data: got %0d expected %0d at pos %0d", a_out_data, exp_q[0], rpos);
      else n_pass++;
      n_checks++;
      if (a_out_pos !== 6'(rpos)) $display("FAIL out_pos: got %0d expected %0d", a_out_pos, rpos);
      else n_pass++;
    end
    if (prev_hold) begin
      n_checks++;
      if ((a_out_data !== prev_data) || (a_out_pos !== prev_pos))
        $display("FAIL hold_stable: got %0d@%0d expected %0d@%0d", a_out_data, a_out_pos, prev_data, prev_pos);
      else n_pass++;
    end
    if (want_wr && !row_loaded) begin
      for (int c = 0; c < 8; c++)
        a_row[63-c*8 -: 8] = (pat != 0) ? 8'($urandom) : 8'(wrow*8 + c);
      row_loaded = 1;
    end
    a_in_valid  = want_wr;
    a_mode      = zz;
    a_out_ready = rdy;
    wf = want_wr && exp_ir;
    rf = rdy && exp_ov;
    prev_hold = exp_ov && !rdy;
    prev_data = a_out_data;
    prev_pos  = a_out_pos;
    @(posedge clk);
    if (rf) begin
      void'(exp_q.pop_front());
      rpos++;
      if (rpos == 64) begin rpos = 0; pend--; end
    end
    if (wf) begin
      for (int c = 0; c < 8; c++) cur[wrow*8 + c] = a_row[63-c*8 -: 8];
      row_loaded = 0;
      wrow++;
      if (wrow == 8) begin
        for (int p = 0; p < 64; p++) exp_q.push_back(zz ? int'(cur[ZZ[p]]) : int'(cur[p]));
        pend++;
        wrow = 0;
        blocks_done++;
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0; a_mode = 0; a_row = '0;
    b_in_valid = 0; b_out_ready = 0; b_mode = 0; b_row = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    blocks_done = 0;
    n_checks++;
    if ({a_in_ready, a_out_valid, a_out_last} !== 3'b100)
      $display("FAIL reset_flags: got rdy/vld/last=%b%b%b expected 100", a_in_ready, a_out_valid, a_out_last);
    else n_pass++;
    n_checks++;
    if ((a_out_data !== 8'd0) || (a_out_pos !== 6'd0) || (a_pend !== 2'd0))
      $display("FAIL reset_values: got data=%0d pos=%0d pend=%0d expected 0 0 0", a_out_data, a_out_pos, a_pend);
    else n_pass++;
    n_checks++;
    if ({b_in_ready, b_out_valid, b_pend} !== 3'b100)
      $display("FAIL reset_single: got rdy/vld/pend=%b%b%b expected 100", b_in_ready, b_out_valid, b_pend);
    else n_pass++;
  endtask

  // Drain whatever is queued while optionally finishing `target` blocks of writes.
  task automatic drain(input int target, input int rdy_pct, input string tag);
    int n = 0;
    while ((blocks_done < target || pend > 0) && n < 8000) begin
      cycle2(blocks_done < target, 1'($urandom % 2), ($urandom % 100) < rdy_pct);
      n++;
    end
    n_checks++;
    if (blocks_done < target || pend > 0)
      $display("FAIL %s_timeout: got %0d blocks %0d pending expected %0d and 0", tag, blocks_done, pend, target);
    else n_pass++;
  endtask

  task automatic test_zigzag();
    pat = 0;
    for (int r = 0; r < 8; r++) cycle2(1, 1, 1);
    drain(blocks_done, 100, "zigzag");
  endtask

  task automatic test_raster();
    pat = 0;
    for (int r = 0; r < 8; r++) cycle2(1, 0, 1);
    drain(blocks_done, 100, "raster");
  endtask

  task automatic test_back_to_back();
    int target;
    pat = 1;
    target = blocks_done + 3;
    for (int k = 0; k < 30; k++) cycle2(1, 1'($urandom % 2), 0);
    drain(target, 100, "back_to_back");
  endtask

  task automatic test_random_backpressure();
    pat = 1;
    drain(blocks_done + 20, 70, "random");
  endtask

  task automatic test_reset_mid();
    pat = 1;
    for (int r = 0; r < 8; r++) cycle2(1, 1'($urandom % 2), 0);
    for (int k = 0; k < 10; k++) cycle2(k < 3, 0, 1);
    rst_n = 1'b0;
    a_in_valid = 0; a_out_ready = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    n_checks++;
    if ({a_in_ready, a_out_valid, a_pend} !== 4'b1000)
      $display("FAIL mid_reset: got rdy/vld/pend=%b/%b/%0d expected 1/0/0", a_in_ready, a_out_valid, a_pend);
    else n_pass++;
    for (int r = 0; r < 8; r++) cycle2(1, 1, 1);
    drain(blocks_done, 100, "after_reset");
  endtask

  // Single bank, always-on traffic: 8 row accepts then 64 read handshakes,
  // and the freed bank accepts the next row on the edge right after the last
  // handshake, so consecutive out_last handshakes are 72 edges apart.
  task automatic test_single_bank();
    int bw = 0, br = 0, blkr = 0, bpos = 0, last_t = -1, cyc = 0, expv;
    bit ok_in, ok_out;
    a_in_valid = 0; a_out_ready = 0;
    while (blkr < 6 && cyc < 1000) begin
      b_in_valid  = 1;
      b_out_ready = 1;
      b_mode      = (bw % 2 == 1);
      for (int c = 0; c < 8; c++) b_row[63-c*8 -: 8] = 8'(bw*13 + br*8 + c);
      n_checks++;
      if ((b_in_ready & b_out_valid) !== 1'b0) $display("FAIL single_overlap: got in_ready=1 with out_valid=1 expected not both");
      else n_pass++;
      if (b_out_valid) begin
        expv = blkr*13 + ((blkr % 2 == 1) ? ZZ[bpos] : bpos);
        n_checks++;
        if ((b_out_data !== 8'(expv)) || (b_out_pos !== 6'(bpos)))
          $display("FAIL single_data: got %0d@%0d expected %0d@%0d", b_out_data, b_out_pos, expv, bpos);
        else n_pass++;
      end
      ok_in  = b_in_ready;
      ok_out = b_out_valid;
      @(posedge clk);
      cyc++;
      if (ok_in) begin br++; if (br == 8) begin br = 0; bw++; end end
      if (ok_out) begin
        bpos++;
        if (bpos == 64) begin
          bpos = 0;
          if (last_t >= 0) begin
            n_checks++;
            if (cyc - last_t !== 72) $display("FAIL single_period: got %0d expected 72", cyc - last_t);
            else n_pass++;
          end
          last_t = cyc;
          blkr++;
        end
      end
      @(negedge clk);
    end
    n_checks++;
    if (blkr != 6) $display("FAIL single_timeout: got %0d blocks expected 6", blkr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_zigzag();
    test_raster();
    test_back_to_back();
    test_random_backpressure();
    test_reset_mid();
    test_single_bank();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
